// File: rtl/uart_rx.sv
// ============================================================================
// Module   : uart_rx
// Purpose  : 8N1 UART receiver with a two-flop input synchronizer, mid-bit
//            sampling, ready/ack handshake, frame-error pulse, sticky overrun.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module uart_rx #(
  parameter int CLK_FREQ  = 25000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_ready,
  input  logic       rx_ack,
  output logic       frame_err,
  output logic       overrun
);

  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [CNT_W-1:0] C_HALF_LAST = CNT_W'(HALF_BIT - 1);
  localparam logic [CNT_W-1:0] C_BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0]       C_IDX_LAST  = 3'd7;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_rx_prev;
  logic [CNT_W-1:0] r_cnt;
  logic [2:0]       r_bit_idx;
  logic [7:0]       r_shift;
  logic [7:0]       r_data;
  logic             r_ready;
  logic             r_ferr;
  logic             r_ovr;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [2:0]       w_idx_nxt;
  logic [7:0]       w_shift_nxt;
  logic             w_good;
  logic             w_bad;
  logic             w_rx_s;
  logic             w_ack;

  assign w_rx_s = r_sync2;
  assign w_ack  = rx_ack & r_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_idx_nxt   = r_bit_idx;
    w_shift_nxt = r_shift;
    w_good      = 1'b0;
    w_bad       = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_rx_prev && !w_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == C_HALF_LAST) begin
          w_cnt_nxt = '0;
          w_idx_nxt = 3'd0;
          // A high line at mid start bit is a glitch, not a frame.
          w_state_nxt = w_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {w_rx_s, r_shift[7:1]};
          w_idx_nxt   = r_bit_idx + 1'b1;
          if (r_bit_idx == C_IDX_LAST) begin
            w_state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          w_good      = w_rx_s;
          w_bad       = !w_rx_s;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
      r_cnt     <= '0;
      r_bit_idx <= 3'd0;
      r_shift   <= 8'h00;
      r_data    <= 8'h00;
      r_ready   <= 1'b0;
      r_ferr    <= 1'b0;
      r_ovr     <= 1'b0;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_bit_idx <= w_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_ferr    <= w_bad;
      if (w_good) begin
        r_data  <= r_shift;
        r_ready <= 1'b1;
        // A same-cycle ack consumes the old byte, so no overrun.
        r_ovr   <= w_ack ? 1'b0 : (r_ovr | r_ready);
      end else if (w_ack) begin
        r_ready <= 1'b0;
        r_ovr   <= 1'b0;
      end
    end
  end

  assign rx_data   = r_data;
  assign rx_ready  = r_ready;
  assign frame_err = r_ferr;
  assign overrun   = r_ovr;

endmodule

`default_nettype wire
